// File: rtl/aes_pkg.sv
// Shared AES datapath types: the 128-bit block seen by the byte assembler,
// block_queue and the cipher stages.
package aes_pkg;
   localparam int BLOCK_BYTES = 16;
   typedef logic [BLOCK_BYTES-1:0][7:0] block_t;
endpackage

// File: rtl/block_queue_if.sv
// Producer/consumer bus of block_queue. drop_count_out exists only when
// BLOCK_QUEUE_DROP_CNT_EN is defined.
interface block_queue_if #(parameter int DEPTH = 4);
   import aes_pkg::*;
   localparam int CW = $clog2(DEPTH) + 1;

   logic          valid_in;
   block_t        block_in;
   logic          ready_in;
   block_t        result_out;
   logic          valid_out;
   logic [CW-1:0] count_out;
   logic          full_out;
   logic          empty_out;
   logic          overflow_out;
`ifdef BLOCK_QUEUE_DROP_CNT_EN
   logic [7:0]    drop_count_out;
`endif

   modport master (
      output valid_in, block_in, ready_in,
      input  result_out, valid_out, count_out, full_out, empty_out, overflow_out
`ifdef BLOCK_QUEUE_DROP_CNT_EN
      , drop_count_out
`endif
   );

   modport slave (
      input  valid_in, block_in, ready_in,
      output result_out, valid_out, count_out, full_out, empty_out, overflow_out
`ifdef BLOCK_QUEUE_DROP_CNT_EN
      , drop_count_out
`endif
   );
endinterface

// File: rtl/block_queue_mem.sv
// DEPTH x block_t register file: synchronous write, combinational read.
// Not reset; the queue masks stale slots while empty.
module block_queue_mem
   import aes_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_in,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  block_t        wdata,
   input  logic [AW-1:0] raddr,
   output block_t        rdata
);
   block_t slot_q [DEPTH];

   always_ff @(posedge clk_in) begin
      if (we) slot_q[waddr] <= wdata;
   end

   assign rdata = slot_q[raddr];
endmodule

// File: rtl/block_queue.sv
// Block FIFO between byte assembler and cipher core with sticky overflow flag.
// Define BLOCK_QUEUE_DROP_CNT_EN to add the saturating drop_count_out counter.
module block_queue
   import aes_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   block_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          empty, full, pop, push, drop;
   block_t        head;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);
   // A full queue still accepts when the head leaves in the same cycle.
   assign pop   = !empty && bus.ready_in;
   assign push  = bus.valid_in && (!full || pop);
   assign drop  = bus.valid_in && full && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q || drop;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   block_queue_mem #(.DEPTH(DEPTH), .AW(PW)) u_mem (
      .clk_in (clk_in),
      .we     (push),
      .waddr  (wr_ptr_q),
      .wdata  (bus.block_in),
      .raddr  (rd_ptr_q),
      .rdata  (head)
   );

`ifdef BLOCK_QUEUE_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign bus.drop_count_out = drop_cnt_q;
`endif

   assign bus.result_out   = empty ? '0 : head;
   assign bus.valid_out    = !empty;
   assign bus.count_out    = count_q;
   assign bus.full_out     = full;
   assign bus.empty_out    = empty;
   assign bus.overflow_out = overflow_q;
endmodule

// File: tb/tb_block_queue.sv
// Self-checking bench for block_queue (DEPTH=4): directed table, corner
// sequences, then random traffic against a queue-based model.
module tb_block_queue;
   import aes_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   block_queue_if #(.DEPTH(DEPTH)) bus ();

   block_queue #(.DEPTH(DEPTH)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a plain queue of blocks plus flags.
   block_t m_q[$];
   bit     m_ovf;
   int     m_drops;

   typedef struct {
      bit          rst;
      bit          valid;
      logic [127:0] blk;
      bit          ready;
      int          exp_count;
      logic [127:0] exp_head;
      bit          exp_ovf;
      int          exp_drops;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit v, input logic [127:0] b, input bit rdy);
      rst          = r;
      bus.valid_in = v;
      bus.block_in = b;
      bus.ready_in = rdy;
   endtask

   // Advance one clock, updating the model from the inputs in force.
   task automatic tick();
      bit pop_now;
      if (rst) begin
         m_q.delete();
         m_ovf   = 0;
         m_drops = 0;
      end else begin
         pop_now = (m_q.size() > 0) && bus.ready_in;
         if (pop_now) void'(m_q.pop_front());
         if (bus.valid_in) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.block_in);
            else begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [127:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 128'd0;
      chk({tag, ".result"}, bus.result_out, head);
      chk({tag, ".valid"}, 128'(bus.valid_out), 128'(m_q.size() > 0));
      chk({tag, ".count"}, 128'(bus.count_out), 128'(m_q.size()));
      chk({tag, ".full"}, 128'(bus.full_out), 128'(m_q.size() == DEPTH));
      chk({tag, ".empty"}, 128'(bus.empty_out), 128'(m_q.size() == 0));
      chk({tag, ".ovf"}, 128'(bus.overflow_out), 128'(m_ovf));
`ifdef BLOCK_QUEUE_DROP_CNT_EN
      chk({tag, ".drops"}, 128'(bus.drop_count_out), 128'(m_drops));
`endif
   endtask

   task automatic check_exp(input string tag, input int cnt, input logic [127:0] head, input bit ovf, input int drops);
      chk({tag, ".count"}, 128'(bus.count_out), 128'(cnt));
      chk({tag, ".result"}, bus.result_out, head);
      chk({tag, ".valid"}, 128'(bus.valid_out), 128'(cnt != 0));
      chk({tag, ".full"}, 128'(bus.full_out), 128'(cnt == DEPTH));
      chk({tag, ".empty"}, 128'(bus.empty_out), 128'(cnt == 0));
      chk({tag, ".ovf"}, 128'(bus.overflow_out), 128'(ovf));
`ifdef BLOCK_QUEUE_DROP_CNT_EN
      chk({tag, ".drops"}, 128'(bus.drop_count_out), 128'(drops));
`else
      if (drops < 0) $display("unused drops %0d", drops);
`endif
   endtask

   localparam logic [127:0] BIG = 128'h00112233_44556677_8899AABB_CCDDEEFF;

   initial begin
      vec_t vecs[$];
      logic [127:0] rb;

      drive(1, 0, 0, 0);
      tick();
      tick();

      // {rst, valid, blk, ready, exp_count, exp_head, exp_ovf, exp_drops}
      vecs.push_back('{1, 0, 128'd0, 0, 0, 128'd0, 0, 0});
      vecs.push_back('{0, 1, BIG,    0, 1, BIG,    0, 0});
      vecs.push_back('{1, 0, 128'd0, 0, 0, 128'd0, 0, 0});
      vecs.push_back('{0, 1, 128'd1, 0, 1, 128'd1, 0, 0});
      vecs.push_back('{0, 1, 128'd2, 0, 2, 128'd1, 0, 0});
      vecs.push_back('{0, 1, 128'd3, 0, 3, 128'd1, 0, 0});
      vecs.push_back('{0, 1, 128'd4, 0, 4, 128'd1, 0, 0});
      vecs.push_back('{0, 1, 128'd5, 0, 4, 128'd1, 1, 1});
      vecs.push_back('{0, 0, 128'd0, 0, 4, 128'd1, 1, 1});
      vecs.push_back('{0, 0, 128'd0, 1, 3, 128'd2, 1, 1});
      vecs.push_back('{0, 0, 128'd0, 1, 2, 128'd3, 1, 1});
      vecs.push_back('{0, 0, 128'd0, 1, 1, 128'd4, 1, 1});
      vecs.push_back('{0, 0, 128'd0, 1, 0, 128'd0, 1, 1});
      vecs.push_back('{0, 0, 128'd0, 1, 0, 128'd0, 1, 1});

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].blk, vecs[i].ready);
         tick();
         check_exp($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_head,
                   vecs[i].exp_ovf, vecs[i].exp_drops);
      end

      // Full queue with simultaneous push and pop wraps the pointers.
      drive(1, 0, 0, 0); tick();
      for (int v = 1; v <= 4; v++) begin
         drive(0, 1, 128'(v), 0); tick();
      end
      drive(0, 1, 128'd9, 1); tick();
      check_exp("pushpop", 4, 128'd2, 0, 0);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 1); tick();
         check_exp($sformatf("wrap%0d", k), 3 - k, (k == 0) ? 128'd3 : (k == 1) ? 128'd4 : (k == 2) ? 128'd9 : 128'd0, 0, 0);
      end

      // Reset with three blocks queued discards them.
      for (int v = 1; v <= 3; v++) begin
         drive(0, 1, 128'(v + 20), 0); tick();
      end
      drive(0, 0, 0, 0); tick();
      check_exp("pre_rst", 3, 128'd21, 0, 0);
      drive(1, 0, 0, 0); tick();
      check_exp("rst3", 0, 128'd0, 0, 0);

      // Random traffic, with occasional resets.
      drive(0, 0, 0, 0);
      for (int c = 0; c < 600; c++) begin
         rb = {$urandom, $urandom, $urandom, $urandom};
         drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), rb,
               ($urandom_range(0, 99) < 45));
         tick();
         check_model($sformatf("rnd%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
